buf_loader: RTL and testbench
=============================

# buf_loader

Byte-stream front end for the motion command buffer. Receives framed host bytes on a valid/ready handshake and assembles 40-bit command words. Writes those words through the executor's buffer write port. Decodes START and ABORT frames into single-cycle `start` and `abort` pulses for the executor. Sits between the host link receiver and the buffer executor.

## Interface
- `TIMEOUT`, 100000: maximum idle cycles between bytes inside a frame.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `in_data` in 8: received byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `ext_buffer_addr` out 16: buffer write address.
- `ext_buffer_data` out 40: buffer write data.
- `ext_buffer_wr` out 1: one-cycle write strobe.
- `start` out 1: one-cycle pulse.
- `start_addr` out 16: valid while `start` is high.
- `abort` out 1: one-cycle pulse.
- `frame_done` out 1: one-cycle pulse at the end of every frame, good or bad.
- `error` out 8: status of the last completed frame.
- `busy` out 1: high in any state other than S_SYNC.

## Operation
- Frame layout: sync 0xA5, opcode, payload, checksum.
- Checksum rule: the checksum byte equals the XOR of the opcode and all payload bytes.
- Opcode 0x01 WRITE:
  - Payload is addr_hi, addr_lo, count, then count × 5 data bytes, MSB first (byte 0 is data[39:32]).
  - count 0 means 256 words.
- Opcode 0x02 START: payload is addr_hi, addr_lo.
- Opcode 0x03 ABORT: no payload.
- States: S_SYNC, S_OPCODE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA, S_CSUM.
- S_SYNC: discard every byte other than 0xA5. On 0xA5, clear the checksum accumulator and go to S_OPCODE.
- S_OPCODE:
  - 0x01 or 0x02: go to S_ADDR_HI.
  - 0x03: go to S_CSUM.
  - Any other value: `error`=0x01, pulse `frame_done`, go to S_SYNC.
- After S_ADDR_LO: WRITE goes to S_COUNT; START goes to S_CSUM.
- WRITE writes on the fly:
  - Each 5th data byte completes a word, which is written at the current address.
  - The address then increments modulo 2^16 (0xFFFF wraps to 0x0000).
  - After the last word, go to S_CSUM.
  - A bad checksum does not roll back writes already made; it only reports the error.
- S_CSUM, match: `error`=0x00.
  - START pulses `start` with the latched `start_addr`.
  - ABORT pulses `abort`.
  - Pulse `frame_done` and go to S_SYNC.
- S_CSUM, mismatch: `error`=0x02, no `start` or `abort`, pulse `frame_done`, go to S_SYNC.
- Timeout: in any state except S_SYNC, if `TIMEOUT` consecutive cycles pass with no accepted byte:
  - `error`=0x03, pulse `frame_done`, go to S_SYNC.
  - A partial word is dropped and not written.
- `error` holds its value until the next frame completes.
- `in_ready`:
  - 1 in every state.
  - 0 while `rst` is high.
  - 0 in the cycle `ext_buffer_wr` is high, if a byte would otherwise be accepted into a new word. This is a single-cycle stall.

## Timing
- Reset values of all outputs: `in_ready`, `ext_buffer_wr`, `start`, `abort`, `frame_done`, `busy` = 0; `ext_buffer_addr`, `ext_buffer_data`, `start_addr`, `error` = 0. State = S_SYNC.
- All outputs are registered.
- Write latency: `ext_buffer_wr` is high exactly 1 cycle, in the cycle after the 5th byte of a word is accepted. Address and data are stable in that same cycle.
- `start`, `abort` and `frame_done` assert in the cycle after the checksum byte is accepted.
- Maximum throughput is one byte per cycle.
- Timeout counter: resets on every accepted byte; expires after exactly `TIMEOUT` idle cycles.
- Reset mid-frame: state returns to S_SYNC, the partial word is discarded, and no pulses are emitted.

## Structure
- Shared package `motion_pkg` holds:
  - sync byte 0xA5;
  - opcode constants `OP_WRITE`, `OP_START`, `OP_ABORT`;
  - error codes 0x00–0x03;
  - the state enumeration.
- Sub-module `word_assembler`: 40-bit shift register plus byte index 0–4, with a `word_valid` output. Everything else is the top-level FSM.

## Test plan
- WRITE at 0x0010, count 2, good checksum -> writes at 0x0010 and 0x0011 with the exact 40-bit words; `error`=0x00; one `frame_done` pulse.
- WRITE at 0xFFFF, count 2 -> writes at 0xFFFF then 0x0000.
- START at 0x1234, good checksum -> one `start` pulse with `start_addr`=0x1234. Same frame with checksum XOR 0x01 -> no `start`, `error`=0x02.
- Garbage bytes 0x00, 0x5A before a valid ABORT frame -> garbage ignored; one `abort` pulse; `error`=0x00.
- Opcode 0x7F -> `error`=0x01, back to S_SYNC. A following valid frame is processed normally.
- WRITE stalled after 3 data bytes for `TIMEOUT` cycles -> no write, `error`=0x03, `busy`=0. Assert `rst` mid-frame in a second run -> all outputs return to 0.

Source files
------------

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared constants for the motion command buffer front end
package motion_pkg;

  typedef logic [2:0] state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_ABORT = 8'h03;

  localparam logic [7:0] ERR_OK      = 8'h00;
  localparam logic [7:0] ERR_OPCODE  = 8'h01;
  localparam logic [7:0] ERR_CSUM    = 8'h02;
  localparam logic [7:0] ERR_TIMEOUT = 8'h03;

  localparam state_t S_SYNC    = 3'd0;
  localparam state_t S_OPCODE  = 3'd1;
  localparam state_t S_ADDR_HI = 3'd2;
  localparam state_t S_ADDR_LO = 3'd3;
  localparam state_t S_COUNT   = 3'd4;
  localparam state_t S_DATA    = 3'd5;
  localparam state_t S_CSUM    = 3'd6;

  localparam int WORD_BYTES = 5;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs five bytes MSB first into a 40-bit command word
module word_assembler
  import motion_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [39:0] word_o,
  output logic        word_valid_o
);

  localparam logic [2:0] LAST_IDX = 3'(WORD_BYTES - 1);

  logic [31:0] shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;

  // The word is presented in the same cycle its last byte arrives; the
  // first four bytes are held in the shift register.
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && !clear_i && (idx_q == LAST_IDX);

  // Shift in bytes and track the byte position; clear drops a partial word.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[23:0], byte_i};
      idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/buf_loader.sv
// rtl/buf_loader.sv - framed byte stream to command buffer writes and start/abort pulses
module buf_loader
  import motion_pkg::*;
#(
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] ext_buffer_addr,
  output logic [39:0] ext_buffer_data,
  output logic        ext_buffer_wr,
  output logic        start,
  output logic [15:0] start_addr,
  output logic        abort,
  output logic        frame_done,
  output logic [7:0]  error,
  output logic        busy
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  words_q, words_d;
  logic [31:0] timer_q, timer_d;

  logic        in_ready_q, in_ready_d;
  logic        wr_q, wr_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [39:0] wr_data_q, wr_data_d;
  logic        start_q, start_d;
  logic [15:0] start_addr_q, start_addr_d;
  logic        abort_q, abort_d;
  logic        done_q, done_d;
  logic [7:0]  error_q, error_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        timeout;
  logic        asm_clear;
  logic        asm_valid;
  logic [39:0] asm_word;
  logic        word_done;

  assign accept    = in_valid && in_ready_q;
  assign timeout   = (state_q != S_SYNC) && !accept && (timer_q == TIMEOUT_LAST);
  assign asm_clear = (state_q != S_DATA);
  assign asm_valid = accept && (state_q == S_DATA);

  word_assembler u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (in_data),
    .word_o       (asm_word),
    .word_valid_o (word_done)
  );

  // Frame parser: sequences header fields, writes words on the fly and
  // reports the frame outcome; the idle timer aborts stalled frames.
  always_comb begin
    state_d      = state_q;
    csum_d       = csum_q;
    op_d         = op_q;
    addr_d       = addr_q;
    words_d      = words_q;
    timer_d      = timer_q;
    in_ready_d   = 1'b1;
    wr_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    start_d      = 1'b0;
    start_addr_d = start_addr_q;
    abort_d      = 1'b0;
    done_d       = 1'b0;
    error_d      = error_q;

    if (state_q == S_SYNC || accept) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 32'd1;
    end

    if (timeout) begin
      error_d = ERR_TIMEOUT;
      done_d  = 1'b1;
      state_d = S_SYNC;
    end else if (accept) begin
      case (state_q)
        S_SYNC: begin
          if (in_data == SYNC_BYTE) begin
            csum_d  = '0;
            state_d = S_OPCODE;
          end
        end
        S_OPCODE: begin
          op_d   = in_data;
          csum_d = csum_q ^ in_data;
          if (in_data == OP_WRITE || in_data == OP_START) begin
            state_d = S_ADDR_HI;
          end else if (in_data == OP_ABORT) begin
            state_d = S_CSUM;
          end else begin
            error_d = ERR_OPCODE;
            done_d  = 1'b1;
            state_d = S_SYNC;
          end
        end
        S_ADDR_HI: begin
          addr_d  = {in_data, addr_q[7:0]};
          csum_d  = csum_q ^ in_data;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = {addr_q[15:8], in_data};
          csum_d  = csum_q ^ in_data;
          state_d = (op_q == OP_WRITE) ? S_COUNT : S_CSUM;
        end
        S_COUNT: begin
          words_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          csum_d  = csum_q ^ in_data;
          state_d = S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q ^ in_data;
          if (word_done) begin
            wr_d      = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = asm_word;
            addr_d    = addr_q + 16'd1;
            words_d   = words_q - 9'd1;
            if (words_q == 9'd1) begin
              state_d = S_CSUM;
            end else begin
              // The next byte starts a new word: hold off one cycle while
              // the write strobe is out.
              in_ready_d = 1'b0;
            end
          end
        end
        S_CSUM: begin
          done_d  = 1'b1;
          state_d = S_SYNC;
          if (in_data == csum_q) begin
            error_d = ERR_OK;
            if (op_q == OP_START) begin
              start_d      = 1'b1;
              start_addr_d = addr_q;
            end
            if (op_q == OP_ABORT) begin
              abort_d = 1'b1;
            end
          end else begin
            error_d = ERR_CSUM;
          end
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end

    busy_d = (state_d != S_SYNC);
  end

  // Parser state and registered outputs; reset drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_SYNC;
      csum_q       <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      words_q      <= '0;
      timer_q      <= '0;
      in_ready_q   <= 1'b0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      start_q      <= 1'b0;
      start_addr_q <= '0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      csum_q       <= csum_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      timer_q      <= timer_d;
      in_ready_q   <= in_ready_d;
      wr_q         <= wr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      start_q      <= start_d;
      start_addr_q <= start_addr_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign ext_buffer_addr = wr_addr_q;
  assign ext_buffer_data = wr_data_q;
  assign ext_buffer_wr   = wr_q;
  assign start           = start_q;
  assign start_addr      = start_addr_q;
  assign abort           = abort_q;
  assign frame_done      = done_q;
  assign error           = error_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_buf_loader.sv
// tb/tb_buf_loader.sv - self-checking bench for buf_loader
module tb_buf_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ext_buffer_addr;
  logic [39:0] ext_buffer_data;
  logic        ext_buffer_wr;
  logic        start;
  logic [15:0] start_addr;
  logic        abort;
  logic        frame_done;
  logic [7:0]  error;
  logic        busy;

  buf_loader #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .ext_buffer_addr (ext_buffer_addr),
    .ext_buffer_data (ext_buffer_data),
    .ext_buffer_wr   (ext_buffer_wr),
    .start           (start),
    .start_addr      (start_addr),
    .abort           (abort),
    .frame_done      (frame_done),
    .error           (error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int gap_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, recorded away from the active edge.
  logic [55:0] obs_wr[$];
  int          obs_start = 0;
  int          obs_abort = 0;
  int          obs_done  = 0;
  int          done_cyc  = 0;
  logic [15:0] obs_start_addr = '0;

  always @(negedge clk) begin
    if (ext_buffer_wr) obs_wr.push_back({ext_buffer_addr, ext_buffer_data});
    if (start) begin
      obs_start++;
      obs_start_addr = start_addr;
    end
    if (abort) obs_abort++;
    if (frame_done) begin
      obs_done++;
      done_cyc = cyc;
    end
  end

  // Reference model output for the frame being sent.
  logic [7:0]  tx[$];
  logic [55:0] exp_wr[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] det_word(input int k, input logic [15:0] a);
    return {a, 8'(k), a} ^ 40'h5A3C0F96E1;
  endfunction

  task automatic build_frame(input logic [7:0] op, input logic [15:0] addr, input int cnt,
                             input logic [7:0] cx, input bit rnd);
    logic [7:0]  cs;
    logic [39:0] w;
    int          n;
    tx.delete();
    exp_wr.delete();
    tx.push_back(8'hA5);
    tx.push_back(op);
    cs = op;
    if (op != 8'h01 && op != 8'h02 && op != 8'h03) return;
    if (op != 8'h03) begin
      tx.push_back(addr[15:8]);
      tx.push_back(addr[7:0]);
      cs = cs ^ addr[15:8] ^ addr[7:0];
    end
    if (op == 8'h01) begin
      tx.push_back(8'(cnt));
      cs = cs ^ 8'(cnt);
      n = (cnt == 0) ? 256 : cnt;
      for (int k = 0; k < n; k++) begin
        w = rnd ? {8'($urandom), 32'($urandom)} : det_word(k, addr);
        for (int j = 4; j >= 0; j--) begin
          tx.push_back(w[j*8 +: 8]);
          cs = cs ^ w[j*8 +: 8];
        end
        exp_wr.push_back({16'((int'(addr) + k) % 65536), w});
      end
    end
    tx.push_back(cs ^ cx);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    int gap;
    gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1 last_acc = cyc;
  endtask

  task automatic run_check(input string nm, input logic [7:0] e_err, input int e_start,
                           input logic [15:0] e_sa, input int e_abort);
    int b_wr, b_st, b_ab, b_dn;
    bit ok;
    b_wr = obs_wr.size();
    b_st = obs_start;
    b_ab = obs_abort;
    b_dn = obs_done;
    foreach (tx[i]) send_byte(tx[i]);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done"}, 64'(obs_done - b_dn), 64'd1);
    chk({nm, "_error"}, error, e_err);
    chk({nm, "_start"}, 64'(obs_start - b_st), 64'(e_start));
    if (e_start > 0) chk({nm, "_start_addr"}, obs_start_addr, e_sa);
    chk({nm, "_abort"}, 64'(obs_abort - b_ab), 64'(e_abort));
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_nwrites"}, 64'(obs_wr.size() - b_wr), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && b_wr + i < obs_wr.size(); i++) begin
      ok = (obs_wr[b_wr + i] === exp_wr[i]);
      chk({nm, "_write"}, obs_wr[b_wr + i], exp_wr[i]);
      if (!ok) break;
    end
  endtask

  typedef struct {
    string       nm;
    logic [7:0]  g0;
    logic [7:0]  g1;
    int          ngarb;
    logic [7:0]  op;
    logic [15:0] addr;
    int          cnt;
    logic [7:0]  cx;
    logic [7:0]  e_err;
    int          e_start;
    int          e_abort;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op, cx, e_err;
    logic [15:0] addr;
    int          kind, cnt, b_wr, b_st, b_ab, b_dn, wait_n;

    vecs[0] = '{"wr_0010",   8'h00, 8'h00, 0, 8'h01, 16'h0010, 2, 8'h00, 8'h00, 0, 0};
    vecs[1] = '{"wr_ffff",   8'h00, 8'h00, 0, 8'h01, 16'hFFFF, 2, 8'h00, 8'h00, 0, 0};
    vecs[2] = '{"start_ok",  8'h00, 8'h00, 0, 8'h02, 16'h1234, 0, 8'h00, 8'h00, 1, 0};
    vecs[3] = '{"start_bad", 8'h00, 8'h00, 0, 8'h02, 16'h1234, 0, 8'h01, 8'h02, 0, 0};
    vecs[4] = '{"abort_grb", 8'h00, 8'h5A, 2, 8'h03, 16'h0000, 0, 8'h00, 8'h00, 0, 1};
    vecs[5] = '{"bad_op",    8'h00, 8'h00, 0, 8'h7F, 16'h0000, 0, 8'h00, 8'h01, 0, 0};
    vecs[6] = '{"after_bad", 8'h00, 8'h00, 0, 8'h02, 16'hBEEF, 0, 8'h00, 8'h00, 1, 0};
    vecs[7] = '{"wr_256",    8'h00, 8'h00, 0, 8'h01, 16'h8000, 0, 8'h00, 8'h00, 0, 0};
    vecs[8] = '{"wr_badcs",  8'h00, 8'h00, 0, 8'h01, 16'h0100, 1, 8'h80, 8'h02, 0, 0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {in_ready, ext_buffer_wr, start, abort, frame_done, busy,
                       ext_buffer_addr, start_addr, error}, 0);
    chk("reset_data", ext_buffer_data, 0);
    rst = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 9; v++) begin
      build_frame(vecs[v].op, vecs[v].addr, vecs[v].cnt, vecs[v].cx, 1'b0);
      if (vecs[v].ngarb > 0) begin
        tx.push_front(vecs[v].g1);
        tx.push_front(vecs[v].g0);
      end
      run_check(vecs[v].nm, vecs[v].e_err, vecs[v].e_start, vecs[v].addr, vecs[v].e_abort);
    end

    // Randomised frames with idle gaps shorter than the timeout.
    gap_max = 4;
    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 3);
      addr = 16'($urandom);
      cx   = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      cnt  = $urandom_range(1, 4);
      case (kind)
        0:       op = 8'h01;
        1:       op = 8'h02;
        2:       op = 8'h03;
        default: op = 8'($urandom_range(4, 255));
      endcase
      if (kind == 3) e_err = 8'h01;
      else if (cx != 0) e_err = 8'h02;
      else e_err = 8'h00;
      build_frame(op, addr, cnt, cx, 1'b1);
      run_check("rand", e_err, (kind == 1 && cx == 0) ? 1 : 0, addr,
                (kind == 2 && cx == 0) ? 1 : 0);
    end
    gap_max = 0;

    // Timeout after three data bytes of a WRITE.
    build_frame(8'h01, 16'h0200, 2, 8'h00, 1'b0);
    b_wr = obs_wr.size();
    b_dn = obs_done;
    for (int i = 0; i < 8; i++) send_byte(tx[i]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("to_busy_mid", busy, 1);
    wait_n = 0;
    while (obs_done == b_dn && wait_n < TO + 20) begin
      @(posedge clk);
      wait_n++;
    end
    @(negedge clk);
    chk("to_done", 64'(obs_done - b_dn), 64'd1);
    chk("to_latency", 64'(done_cyc - last_acc), 64'(TO));
    chk("to_error", error, 8'h03);
    chk("to_busy", busy, 0);
    chk("to_nwrites", 64'(obs_wr.size() - b_wr), 64'd0);
    build_frame(8'h01, 16'h0207, 1, 8'h00, 1'b0);
    run_check("after_to", 8'h00, 0, 16'h0000, 0);

    // Reset in the middle of a WRITE, one word written and a partial word pending.
    build_frame(8'h01, 16'h0300, 3, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) send_byte(tx[i]);
    @(negedge clk);
    in_valid = 1'b0;
    b_wr = obs_wr.size();
    b_st = obs_start;
    b_ab = obs_abort;
    b_dn = obs_done;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {in_ready, ext_buffer_wr, start, abort, frame_done, busy,
                         ext_buffer_addr, start_addr, error}, 0);
    chk("rst_mid_data", ext_buffer_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ready", in_ready, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_pulses", 64'((obs_wr.size() - b_wr) + (obs_start - b_st) +
                              (obs_abort - b_ab) + (obs_done - b_dn)), 64'd0);
    build_frame(8'h01, 16'h0400, 2, 8'h00, 1'b1);
    run_check("after_rst", 8'h00, 0, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
